// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: combinational fetch lookup,
// decode-stage training, and a registered one-cycle redirect on mispredict.
module branch_predictor #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_WIDTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lookup_valid_i,
    input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
    output logic                  pred_taken_o,
    output logic [ADDR_WIDTH-1:0] pred_target_o,
    input  logic                  upd_valid_i,
    input  logic [ADDR_WIDTH-1:0] upd_pc_i,
    input  logic                  upd_is_branch_i,
    input  logic                  upd_taken_i,
    input  logic [ADDR_WIDTH-1:0] upd_target_i,
    input  logic                  upd_pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target_i,
    output logic                  flush_o,
    output logic [ADDR_WIDTH-1:0] flush_addr_o
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

    localparam logic [CNT_WIDTH-1:0] CntMax    = '1;
    localparam logic [CNT_WIDTH-1:0] CntWeakT  = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CntWeakNt = CntWeakT - CNT_WIDTH'(1);

    logic                  valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0]      tag_q   [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] tgt_q   [BTB_ENTRIES];
    logic [CNT_WIDTH-1:0]  cnt_q   [BTB_ENTRIES];

    logic [IDX_W-1:0]      lk_idx, up_idx;
    logic [TAG_W-1:0]      lk_tag, up_tag;
    logic                  lk_hit, up_hit;

    logic                  wr_en, wr_valid;
    logic [TAG_W-1:0]      wr_tag;
    logic [ADDR_WIDTH-1:0] wr_tgt;
    logic [CNT_WIDTH-1:0]  wr_cnt;

    logic [ADDR_WIDTH-1:0] upd_seq, actual_pc, predicted_pc;
    logic                  flush_d, flush_q;
    logic [ADDR_WIDTH-1:0] flush_addr_d, flush_addr_q;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[ADDR_WIDTH-1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[ADDR_WIDTH-1:IDX_W+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads the registered array only; an update in the same cycle is not bypassed.
    assign pred_taken_o  = lookup_valid_i & lk_hit & cnt_q[lk_idx][CNT_WIDTH-1];
    assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : lookup_pc_i + ADDR_WIDTH'(4);

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = valid_q[up_idx];
        wr_tag   = tag_q[up_idx];
        wr_tgt   = tgt_q[up_idx];
        wr_cnt   = cnt_q[up_idx];
        if (upd_valid_i) begin
            if (upd_is_branch_i) begin
                if (up_hit) begin
                    wr_en = 1'b1;
                    if (upd_taken_i) begin
                        wr_tgt = upd_target_i;
                        if (cnt_q[up_idx] != CntMax) wr_cnt = cnt_q[up_idx] + CNT_WIDTH'(1);
                    end else if (cnt_q[up_idx] != '0) begin
                        wr_cnt = cnt_q[up_idx] - CNT_WIDTH'(1);
                    end
                end else if (upd_taken_i) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_tag   = up_tag;
                    wr_tgt   = upd_target_i;
                    wr_cnt   = CntWeakT;
                end
            end else if (up_hit) begin
                // Non-branch hitting an entry means a stale alias; drop it.
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    always_comb begin
        upd_seq      = upd_pc_i + ADDR_WIDTH'(4);
        actual_pc    = upd_taken_i ? upd_target_i : upd_seq;
        predicted_pc = upd_pred_taken_i ? upd_pred_target_i : upd_seq;
        flush_d      = 1'b0;
        flush_addr_d = flush_addr_q;
        if (upd_valid_i) begin
            if (upd_is_branch_i) begin
                if (actual_pc != predicted_pc) begin
                    flush_d      = 1'b1;
                    flush_addr_d = actual_pc;
                end
            end else if (upd_pred_taken_i) begin
                flush_d      = 1'b1;
                flush_addr_d = upd_seq;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CntWeakNt;
            end
        end else if (wr_en) begin
            valid_q[up_idx] <= wr_valid;
            tag_q[up_idx]   <= wr_tag;
            tgt_q[up_idx]   <= wr_tgt;
            cnt_q[up_idx]   <= wr_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_q      <= 1'b0;
            flush_addr_q <= '0;
        end else begin
            flush_q      <= flush_d;
            flush_addr_q <= flush_addr_d;
        end
    end

    assign flush_o      = flush_q;
    assign flush_addr_o = flush_addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized check of branch_predictor against a table-based reference model.
module tb_branch_predictor;

    localparam int unsigned N    = 16;
    localparam int          CMAX = 3;
    localparam int          HALF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid, upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
    logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
    logic        pred_taken, flush;
    logic [31:0] pred_target, flush_addr;

    branch_predictor #(
        .ADDR_WIDTH (32),
        .BTB_ENTRIES(N),
        .CNT_WIDTH  (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .lookup_valid_i   (lookup_valid),
        .lookup_pc_i      (lookup_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_is_branch_i  (upd_is_branch),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target),
        .upd_pred_taken_i (upd_pred_taken),
        .upd_pred_target_i(upd_pred_target),
        .flush_o          (flush),
        .flush_addr_o     (flush_addr)
    );

    always #5 clk = ~clk;

    // Reference model: one record per slot, keyed by (pc / 4) mod N, tag = pc / (4 * N).
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    bit          m_flush;
    logic [31:0] m_faddr;

    int n_pass  = 0;
    int n_total = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_cnt[i]   = HALF - 1;
        end
        m_flush = 0;
        m_faddr = '0;
    endtask

    task automatic model_pred(input bit lv, input logic [31:0] pc, output bit tk,
                              output logic [31:0] tgt);
        int s = slot(pc);
        tk  = lv && m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_cnt[s] >= HALF);
        tgt = tk ? m_tgt[s] : pc + 32'd4;
    endtask

    task automatic model_update(input bit uv, input logic [31:0] pc, input bit br, input bit tk,
                                input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        int          s   = slot(pc);
        bit          hit = m_valid[s] && (m_tag[s] == tag_of(pc));
        logic [31:0] act, prd;
        m_flush = 0;
        if (!uv) return;
        act = tk ? tgt : pc + 32'd4;
        prd = ptk ? ptgt : pc + 32'd4;
        if (br && act != prd) begin
            m_flush = 1;
            m_faddr = act;
        end else if (!br && ptk) begin
            m_flush = 1;
            m_faddr = pc + 32'd4;
        end
        if (br) begin
            if (hit) begin
                if (tk) begin
                    m_cnt[s] = (m_cnt[s] + 1 > CMAX) ? CMAX : m_cnt[s] + 1;
                    m_tgt[s] = tgt;
                end else begin
                    m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
                end
            end else if (tk) begin
                m_valid[s] = 1;
                m_tag[s]   = tag_of(pc);
                m_tgt[s]   = tgt;
                m_cnt[s]   = HALF;
            end
        end else if (hit) begin
            m_valid[s] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, got, exp);
    endtask

    // One cycle: drive, check combinational lookup, clock, check registered redirect.
    task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit br, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        bit          e_tk;
        logic [31:0] e_tgt;
        lookup_valid    = lv;
        lookup_pc       = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_is_branch   = br;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        #1;
        model_pred(lv, lpc, e_tk, e_tgt);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
        chk("pred_target", pred_target, e_tgt);
        @(posedge clk);
        #1;
        model_update(uv, upc, br, tk, tgt, ptk, ptgt);
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("flush_addr", flush_addr, m_faddr);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1, pc, 0, '0, 0, 0, '0, 0, '0);
    endtask

    // Branch resolution carrying the prediction fetch would have made for that PC.
    task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        bit          ptk;
        logic [31:0] ptgt;
        model_pred(1, pc, ptk, ptgt);
        step(0, '0, 1, pc, 1, tk, tgt, ptk, ptgt);
    endtask

    localparam logic [31:0] P = 32'h0040_0010;
    localparam logic [31:0] T = 32'h0040_0100;

    initial begin
        bit          r_br, r_tk, r_ptk;
        logic [31:0] r_pc, r_lpc, r_tgt, r_ptgt;

        rst_n = 1'b0;
        lookup_valid = 0; lookup_pc = '0; upd_valid = 0; upd_pc = '0; upd_is_branch = 0;
        upd_taken = 0; upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_flush_addr", flush_addr, 32'd0);

        // Reset state lookup, then a cold taken branch with a same-cycle lookup.
        look(32'h0040_0000);
        step(1, P, 1, P, 1, 1, T, 0, '0);
        look(P);

        // Counter saturation walk.
        resolve(P, 1, T);
        resolve(P, 1, T);
        look(P);
        resolve(P, 0, '0);
        look(P);
        resolve(P, 0, '0);
        look(P);
        for (int i = 0; i < 5; i++) resolve(P, 0, '0);
        look(P);
        resolve(P, 1, T);
        look(P);
        resolve(P, 1, T);
        look(P);

        // Aliasing, then invalidation by a non-branch that was predicted taken.
        look(32'h0040_0050);
        step(0, '0, 1, P, 0, 0, '0, 1, T);
        look(P);

        // Correct prediction; lookup in the same cycle sees the pre-update (empty) entry.
        step(1, P, 1, P, 1, 1, T, 1, T);
        look(P);
        step(0, '0, 1, P, 1, 1, T, 1, T);

        // PC+4 wrap, idle lookup, non-branch miss.
        look(32'hFFFF_FFFC);
        step(0, 32'h0040_0020, 0, '0, 0, 0, '0, 0, '0);
        step(1, 32'h0040_0030, 1, 32'h0040_0030, 0, 0, '0, 0, '0);

        // Back-to-back mispredicts, each with its own redirect address.
        step(0, '0, 1, 32'h0040_0040, 1, 1, 32'h0040_0200, 0, '0);
        step(0, '0, 1, 32'h0040_0044, 1, 0, '0, 1, 32'h0040_0300);
        step(0, '0, 1, 32'h0040_0044, 1, 1, 32'h0040_0400, 1, 32'h0040_0404);

        // Randomized traffic on a small PC window to force aliasing.
        for (int i = 0; i < 400; i++) begin
            r_pc   = 32'h0040_0000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            r_lpc  = ($urandom_range(0, 1) == 1) ? r_pc
                                                 : 32'h0040_0000 + ($urandom_range(0, 63) << 2);
            r_br   = ($urandom_range(0, 3) != 0);
            r_tk   = ($urandom_range(0, 2) != 0);
            r_tgt  = 32'h0040_0000 + ($urandom_range(0, 15) << 4);
            r_ptk  = $urandom_range(0, 1) == 1;
            r_ptgt = ($urandom_range(0, 1) == 1) ? r_tgt : $urandom();
            step($urandom_range(0, 3) != 0, r_lpc, $urandom_range(0, 4) != 0, r_pc, r_br, r_tk,
                 r_tgt, r_ptk, r_ptgt);
        end

        // Asynchronous reset while a redirect is being presented.
        resolve(P, 1, 32'h0040_0500);
        if (!m_flush) step(0, '0, 1, P, 1, 1, 32'h0040_0600, 0, '0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_flush", {31'd0, flush}, 32'd0);
        chk("async_flush_addr", flush_addr, 32'd0);
        #1;
        rst_n = 1'b1;
        look(P);
        look(32'h0040_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction and resolution unit for the TinyMIPS core. It holds a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. The fetch stage looks it up combinationally, and the decode stage trains it with the resolved outcome of every branch or jump (BEQ/BNE/J/JAL/JR/JALR). It compares each resolved outcome against the prediction made for that instruction and raises a registered one-cycle redirect on mispredict, extending decode-stage branch generation to predicted fetch.

## Interface
Parameters:
- ADDR_WIDTH, 32: PC and target width.
- BTB_ENTRIES, 16: number of BTB entries; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).
- CNT_WIDTH, 2: direction counter width, ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- lookup_valid  in  1  fetch stage presents a PC.
- lookup_pc  in  ADDR_WIDTH  fetch PC.
- pred_taken  out  1  predicted taken for lookup_pc (combinational).
- pred_target  out  ADDR_WIDTH  predicted next PC (combinational).
- upd_valid  in  1  decode stage presents a resolved instruction.
- upd_pc  in  ADDR_WIDTH  PC of resolved instruction.
- upd_is_branch  in  1  instruction is a branch/jump.
- upd_taken  in  1  resolved direction (always 1 for jumps).
- upd_target  in  ADDR_WIDTH  resolved target (valid when upd_taken).
- upd_pred_taken  in  1  prediction made at fetch, piped down.
- upd_pred_target  in  ADDR_WIDTH  predicted next PC, piped down.
- flush  out  1  registered mispredict redirect pulse.
- flush_addr  out  ADDR_WIDTH  correct next PC when flush=1.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2]; pc[1:0] ignored.
- Each entry holds: valid, tag, target, and a CNT_WIDTH-bit counter.
- Hit = entry valid and tag equal.
- Lookup:
  - pred_taken = lookup_valid & hit & counter MSB.
  - pred_target = pred_taken ? entry target : lookup_pc+4.
  - PC+4 wraps modulo 2^ADDR_WIDTH.
- Update applies only when upd_valid=1:
  - Branch, hit: counter +1 if taken, −1 if not, saturating at all-ones and zero. Target overwritten with upd_target when taken.
  - Branch, miss, taken: allocate (replace any occupant). Set valid, tag, target; counter = 1<<(CNT_WIDTH-1) (weakly taken).
  - Branch, miss, not taken: no change.
  - Non-branch, hit: clear valid. This removes stale aliases.
  - Non-branch, miss: no change.
- Mispredict check when upd_valid & upd_is_branch:
  - actual = upd_taken ? upd_target : upd_pc+4.
  - predicted = upd_pred_taken ? upd_pred_target : upd_pc+4.
  - If actual ≠ predicted: next cycle flush=1 and flush_addr=actual.
- Non-branch with upd_pred_taken=1 (alias hit at fetch): flush=1, flush_addr=upd_pc+4.
- Otherwise flush=0 next cycle; flush_addr holds its last value.

## Timing
- Reset (rst=0, asynchronous, effective immediately even mid-update):
  - all valid=0; counters = (1<<(CNT_WIDTH-1))−1 (weakly not taken); targets/tags = 0.
  - flush=0, flush_addr=0.
  - Hence pred_taken=0, pred_target=lookup_pc+4.
- Lookup latency 0 cycles (combinational from registered array).
- Update latency 1 cycle: a write at edge N is visible to lookups after edge N.
- Simultaneous lookup and update to the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- flush asserts exactly one cycle per offending update. Back-to-back mispredicts give consecutive flush cycles, each with its own flush_addr.
- upd_valid=0: no state change; flush=0 next cycle.
- Deassertion of rst is synchronised externally. The block's first update is honoured on the first edge after release.

## Test plan
- Reset: after rst=0 then release, lookup_pc=0x00400000, lookup_valid=1 → pred_taken=0, pred_target=0x00400004, flush=0, flush_addr=0.
- Cold taken branch: upd pc=0x00400010, taken, target=0x00400100, pred_taken=0 → flush=1, flush_addr=0x00400100 next cycle. Then lookup 0x00400010 → pred_taken=1, pred_target=0x00400100.
- Counter saturation (CNT_WIDTH=2):
  - Train taken 3× → counter 11.
  - One not-taken → 10, still predicts taken.
  - Second not-taken → 01, predicts not taken.
  - Five further not-taken → stays 00.
- Aliasing (BTB_ENTRIES=16):
  - Entry for 0x00400010 valid.
  - Lookup 0x00400050 (same index, different tag) → miss, pred_target=0x00400054.
  - Update non-branch at 0x00400010 → entry invalidated.
- Correct prediction: upd taken, target 0x00400100, upd_pred_taken=1, upd_pred_target=0x00400100 → flush stays 0. Lookup and update to the same index in one cycle → lookup shows old entry.
- Async reset mid-flush: rst=0 while flush=1 → flush drops to 0 without a clock edge; all entries invalid afterwards.
